// File: rtl/disp_scan_pkg.sv
// disp_scan_pkg: shared constants, frame payload type and hex-to-segment table
// for the multiplexed 4-digit seven-segment scanner.
package disp_scan_pkg;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HEX_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DEAD_W = 4;
    localparam int unsigned DIN_W  = NDIG * HEX_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [NDIG-1:0]  AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; element 15 first, element 0 last.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // One full frame of display content: digits, decimal points, enables.
    typedef struct packed {
        logic [DIN_W-1:0] din;
        logic [NDIG-1:0]  dp;
        logic [NDIG-1:0]  en;
    } frame_t;

endpackage

// File: rtl/disp_scan_if.sv
// disp_scan_if: bus between a display data source and the scanner.
//   disp_clk        slow scan clock (clk domain), rising edge steps a digit
//   load/din/dp_in/en_in   frame load strobe and payload
//   an/seg/dp       active-low anode, segment and decimal-point drives
//   pending         staged frame waiting for the next wrap
//   frame_start     one-cycle pulse when the scan returns to digit 0
interface disp_scan_if;
    import disp_scan_pkg::*;

    logic              disp_clk;
    logic              load;
    logic [DIN_W-1:0]  din;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   en_in;
    logic [NDIG-1:0]   an;
    logic [SEG_W-1:0]  seg;
    logic              dp;
    logic              pending;
    logic              frame_start;

    modport master (
        output disp_clk, load, din, dp_in, en_in,
        input  an, seg, dp, pending, frame_start
    );

    modport slave (
        input  disp_clk, load, din, dp_in, en_in,
        output an, seg, dp, pending, frame_start
    );

endinterface

// File: rtl/disp_scan_hex7seg.sv
// hex7seg: combinational hex digit to active-low seven-segment decode.
//   i_hex    4-bit hex digit
//   o_seg_c  {g,f,e,d,c,b,a}, active-low
module hex7seg
    import disp_scan_pkg::*;
(
    input  logic [HEX_W-1:0] i_hex,
    output logic [SEG_W-1:0] o_seg_c
);

    assign o_seg_c = HEX_SEG[i_hex];

endmodule

// File: rtl/disp_scan.sv
// disp_scan: 4-digit multiplexed seven-segment scanner with double-buffered
// frame data and a dead time between digits to suppress ghosting.
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   disp_scan_if.slave (scan clock, frame load in; an/seg/dp,
//         pending, frame_start out, all registered)
// DEAD: cycles all anodes stay off after each digit step, legal 1..15.
module disp_scan
    import disp_scan_pkg::*;
#(
    parameter int unsigned DEAD = 2
)
(
    input  logic       clk,
    input  logic       rstn,
    disp_scan_if.slave bus
);

    logic              r_prev;
    logic [IDX_W-1:0]  r_idx;
    logic [DEAD_W-1:0] r_dead;
    frame_t            r_stg;
    frame_t            r_act;
    logic              r_pending;
    logic              r_frame;
    logic [NDIG-1:0]   r_an;
    logic [SEG_W-1:0]  r_seg;
    logic              r_dp;

    logic              w_tick;
    logic              w_wrap;
    logic [IDX_W-1:0]  w_idx_nxt;
    frame_t            w_load_frame;
    frame_t            w_act_nxt;
    logic [HEX_W-1:0]  w_nib;
    logic [SEG_W-1:0]  w_dec;
    logic              w_en_nxt;
    logic              w_dp_nxt;
    logic              w_en_cur;
    logic [NDIG-1:0]   w_an_sel;

    // Rising edge of the scan clock; falling edges are ignored.
    assign w_tick    = bus.disp_clk & ~r_prev;
    assign w_wrap    = w_tick & (r_idx == IDX_W'(NDIG - 1));
    assign w_idx_nxt = r_idx + IDX_W'(1);

    assign w_load_frame = '{din: bus.din, dp: bus.dp_in, en: bus.en_in};

    // Segments for the digit being stepped to must come from the frame that
    // will be active after this tick, which on a wrap is the staged one.
    assign w_act_nxt = w_wrap ? r_stg : r_act;
    assign w_nib     = w_act_nxt.din[{w_idx_nxt, 2'b00} +: HEX_W];
    assign w_en_nxt  = w_act_nxt.en[w_idx_nxt];
    assign w_dp_nxt  = w_act_nxt.dp[w_idx_nxt];

    assign w_en_cur  = r_act.en[r_idx];
    assign w_an_sel  = ~(NDIG'(1) << r_idx);

    hex7seg u_hex7seg (
        .i_hex   (w_nib),
        .o_seg_c (w_dec)
    );

    // Scan position, double buffer and frame status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev    <= 1'b0;
            r_idx     <= '0;
            r_stg     <= '0;
            r_act     <= '0;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_prev  <= bus.disp_clk;
            r_frame <= w_wrap;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
            end
            if (w_wrap) begin
                r_act <= r_stg;
            end
            if (bus.load) begin
                r_stg <= w_load_frame;
            end
            // A load on the wrap cycle lands after the transfer, so it stays pending.
            if (bus.load) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Output drive: blank anodes on every step, light the digit when the
    // dead counter expires; segments settle during the dead time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dead <= '0;
            r_an   <= AN_OFF;
            r_seg  <= SEG_BLANK;
            r_dp   <= 1'b1;
        end else if (w_tick) begin
            r_dead <= DEAD_W'(DEAD);
            r_an   <= AN_OFF;
            r_seg  <= w_en_nxt ? w_dec : SEG_BLANK;
            r_dp   <= ~(w_en_nxt & w_dp_nxt);
        end else if (r_dead != '0) begin
            r_dead <= r_dead - DEAD_W'(1);
            if (r_dead == DEAD_W'(1)) begin
                r_an <= w_en_cur ? w_an_sel : AN_OFF;
            end
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.pending     = r_pending;
    assign bus.frame_start = r_frame;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed, table-driven bench for disp_scan (DEAD=2).
module tb_disp_scan;
    import disp_scan_pkg::*;

    localparam int unsigned DEAD = 2;
    localparam int NV = 16;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    disp_scan_if bus ();

    disp_scan #(.DEAD(DEAD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        frame_t     f;
        logic [1:0] d;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } vec_t;

    vec_t       vt [NV];
    int         n_vec = 0;
    int         n_err = 0;
    int         frame_cnt = 0;
    int         fc0;
    logic [1:0] tb_idx;
    logic [1:0] prev_d;
    frame_t     tb_stg;
    frame_t     tb_act;
    frame_t     f1234, fa, fb, fc, faaaa, f5555, f3333, fffff;

    always @(negedge clk) if (bus.frame_start === 1'b1) frame_cnt = frame_cnt + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Scan clock high for one clk cycle; returns at T+1.
    task automatic tick();
        bus.disp_clk = 1'b1;
        step();
        bus.disp_clk = 1'b0;
        if (tb_idx == 2'd3) tb_act = tb_stg;
        tb_idx = tb_idx + 2'd1;
    endtask

    task automatic tick_idle();
        tick();
        idle(DEAD + 2);
    endtask

    task automatic load(input frame_t f);
        bus.load  = 1'b1;
        bus.din   = f.din;
        bus.dp_in = f.dp;
        bus.en_in = f.en;
        step();
        bus.load  = 1'b0;
        tb_stg    = f;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        f1234 = '{din: 16'h1234, dp: 4'b0000, en: 4'b1111};
        fa    = '{din: 16'h0F8A, dp: 4'b0101, en: 4'b1011};
        fb    = '{din: 16'hBCDE, dp: 4'b1000, en: 4'b1111};
        fc    = '{din: 16'h9765, dp: 4'b0010, en: 4'b1111};
        faaaa = '{din: 16'hAAAA, dp: 4'b0000, en: 4'b1111};
        f5555 = '{din: 16'h5555, dp: 4'b0000, en: 4'b1111};
        f3333 = '{din: 16'h3333, dp: 4'b0000, en: 4'b1111};
        fffff = '{din: 16'hFFFF, dp: 4'b0000, en: 4'b1111};

        vt[0]  = '{f1234, 2'd0, 7'h19, 1'b1, 4'hE};
        vt[1]  = '{f1234, 2'd1, 7'h30, 1'b1, 4'hD};
        vt[2]  = '{f1234, 2'd2, 7'h24, 1'b1, 4'hB};
        vt[3]  = '{f1234, 2'd3, 7'h79, 1'b1, 4'h7};
        vt[4]  = '{fa,    2'd0, 7'h08, 1'b0, 4'hE};
        vt[5]  = '{fa,    2'd1, 7'h00, 1'b1, 4'hD};
        vt[6]  = '{fa,    2'd2, 7'h7F, 1'b1, 4'hF};
        vt[7]  = '{fa,    2'd3, 7'h40, 1'b1, 4'h7};
        vt[8]  = '{fb,    2'd0, 7'h06, 1'b1, 4'hE};
        vt[9]  = '{fb,    2'd1, 7'h21, 1'b1, 4'hD};
        vt[10] = '{fb,    2'd2, 7'h46, 1'b1, 4'hB};
        vt[11] = '{fb,    2'd3, 7'h03, 1'b0, 4'h7};
        vt[12] = '{fc,    2'd0, 7'h12, 1'b1, 4'hE};
        vt[13] = '{fc,    2'd1, 7'h02, 1'b0, 4'hD};
        vt[14] = '{fc,    2'd2, 7'h78, 1'b1, 4'hB};
        vt[15] = '{fc,    2'd3, 7'h10, 1'b1, 4'h7};

        // Reset state
        bus.disp_clk = 1'b0;
        bus.load     = 1'b0;
        bus.din      = '0;
        bus.dp_in    = '0;
        bus.en_in    = '0;
        rstn         = 1'b0;
        tb_idx       = '0;
        tb_act       = '0;
        tb_stg       = '0;
        idle(2);
        chk4("rst_an", bus.an, 4'hF);
        chk7("rst_seg", bus.seg, 7'h7F);
        chk1("rst_dp", bus.dp, 1'b1);
        chk1("rst_pending", bus.pending, 1'b0);
        chk1("rst_frame", bus.frame_start, 1'b0);
        rstn = 1'b1;
        idle(3);
        chk4("post_rst_an", bus.an, 4'hF);

        // Load 1234: pending until the 4th tick, one frame_start
        fc0 = frame_cnt;
        load(f1234);
        chk1("load_pending", bus.pending, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick_idle();
            chk1("pend_hold", bus.pending, 1'b1);
            chk4("pre_wrap_an", bus.an, 4'hF);
        end
        tick();
        chk1("wrap_pending", bus.pending, 1'b0);
        chk1("wrap_frame", bus.frame_start, 1'b1);
        chk7("wrap_seg", bus.seg, 7'h19);
        chk4("wrap_an_t1", bus.an, 4'hF);
        step();
        chk4("wrap_an_t2", bus.an, 4'hF);
        step();
        chk4("wrap_an_t3", bus.an, 4'hE);
        idle(2);
        chki("frame_cnt", frame_cnt - fc0, 1);

        // Table: per digit, checked at T+1, T+2, T+3 of the tick that selects it
        for (int i = 0; i < NV; i++) begin
            if (vt[i].f != tb_act) begin
                load(vt[i].f);
                while (tb_idx != 2'd3) tick_idle();
            end
            prev_d = vt[i].d - 2'd1;
            while (tb_idx != prev_d) tick_idle();
            tick();
            chk7("v_seg_t1", bus.seg, vt[i].seg);
            chk1("v_dp_t1", bus.dp, vt[i].dp);
            chk4("v_an_t1", bus.an, 4'hF);
            chk1("v_frame", bus.frame_start, vt[i].d == 2'd0);
            chk1("v_pending", bus.pending, 1'b0);
            step();
            chk4("v_an_t2", bus.an, 4'hF);
            step();
            chk4("v_an_t3", bus.an, vt[i].an);
            chk7("v_seg_t3", bus.seg, vt[i].seg);
            idle(1);
        end

        // Two loads in one frame: last wins
        tick_idle();
        load(faaaa);
        tick_idle();
        load(f5555);
        chk1("dbl_pending", bus.pending, 1'b1);
        tick_idle();
        tick_idle();
        tick();
        chk7("dbl_seg0", bus.seg, 7'h12);
        chk1("dbl_pending_clr", bus.pending, 1'b0);
        chk1("dbl_frame", bus.frame_start, 1'b1);
        idle(2);
        chk4("dbl_an0", bus.an, 4'hE);
        idle(1);
        tick();
        chk7("dbl_seg1", bus.seg, 7'h12);
        idle(2);
        chk4("dbl_an1", bus.an, 4'hD);
        idle(1);

        // Load coinciding with the wrap tick
        load(f3333);
        while (tb_idx != 2'd3) tick_idle();
        bus.disp_clk = 1'b1;
        bus.load     = 1'b1;
        bus.din      = fffff.din;
        bus.dp_in    = fffff.dp;
        bus.en_in    = fffff.en;
        step();
        bus.disp_clk = 1'b0;
        bus.load     = 1'b0;
        tb_act       = tb_stg;
        tb_stg       = fffff;
        tb_idx       = 2'd0;
        chk7("cw_seg", bus.seg, 7'h30);
        chk1("cw_pending", bus.pending, 1'b1);
        chk1("cw_frame", bus.frame_start, 1'b1);
        idle(2);
        chk4("cw_an", bus.an, 4'hE);
        idle(1);
        tick_idle();
        tick_idle();
        tick_idle();
        chk7("cw_seg3", bus.seg, 7'h30);
        tick();
        chk7("cw_seg_f", bus.seg, 7'h0E);
        chk1("cw_pending_clr", bus.pending, 1'b0);
        idle(2);
        chk4("cw_an_f", bus.an, 4'hE);
        idle(1);

        // Tick inside dead time restarts it and still advances the digit
        bus.disp_clk = 1'b1;
        step();
        bus.disp_clk = 1'b0;
        chk4("fast_an_t1", bus.an, 4'hF);
        step();
        chk4("fast_an_t2", bus.an, 4'hF);
        bus.disp_clk = 1'b1;
        step();
        bus.disp_clk = 1'b0;
        tb_idx = tb_idx + 2'd2;
        chk4("fast_an_t3", bus.an, 4'hF);
        step();
        chk4("fast_an_t4", bus.an, 4'hF);
        step();
        chk4("fast_an_t5", bus.an, 4'hB);

        // Asynchronous reset while digit 2 is lit, with a frame pending
        load(f1234);
        chk4("pre_rst_an", bus.an, 4'hB);
        chk1("pre_rst_pending", bus.pending, 1'b1);
        rstn = 1'b0;
        #1;
        chk4("arst_an", bus.an, 4'hF);
        chk7("arst_seg", bus.seg, 7'h7F);
        chk1("arst_dp", bus.dp, 1'b1);
        chk1("arst_pending", bus.pending, 1'b0);
        step();
        rstn   = 1'b1;
        tb_idx = '0;
        tb_act = '0;
        tb_stg = '0;
        idle(3);
        chk4("rel_an", bus.an, 4'hF);
        tick();
        chk1("rel_frame1", bus.frame_start, 1'b0);
        chk7("rel_seg1", bus.seg, 7'h7F);
        idle(2);
        chk4("rel_an1", bus.an, 4'hF);
        idle(1);
        tick_idle();
        tick_idle();
        tick();
        chk1("rel_frame4", bus.frame_start, 1'b1);
        chk7("rel_seg_wrap", bus.seg, 7'h7F);
        idle(2);
        chk4("rel_an_wrap", bus.an, 4'hF);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
